// File: rtl/decryption_if.sv
// rtl/decryption_if.sv - request/result bundle for the ACORN-128 decryption core
interface decryption_if;
  logic         start;
  logic [292:0] state_in;
  logic [127:0] cipher_in;
  logic [127:0] plain_out;
  logic [292:0] state_out;
  logic         busy;
  logic         done;

  modport master (
    output start, state_in, cipher_in,
    input  plain_out, state_out, busy, done
  );

  modport slave (
    input  start, state_in, cipher_in,
    output plain_out, state_out, busy, done
  );
endinterface

// File: rtl/decryption.sv
// rtl/decryption.sv - bit-serial ACORN-128 single-block decryption with 256-step padding
module decryption (
  input  logic         clk,
  input  logic         rst,
  decryption_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DEC, PAD} fsm_t;

  fsm_t         fsm;
  logic [292:0] s;
  logic [127:0] c;
  logic [127:0] p;
  logic [8:0]   cnt;
  logic         busy_r;
  logic         done_r;

  logic [292:0] t;
  logic [292:0] s_next;
  logic         ks;
  logic         m;
  logic         ca;
  logic         f;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  always_comb begin
    t      = s;
    t[289] = s[289] ^ s[235] ^ s[230];
    t[230] = s[230] ^ s[196] ^ s[193];
    t[193] = s[193] ^ s[160] ^ s[154];
    t[154] = s[154] ^ s[111] ^ s[107];
    t[107] = s[107] ^ s[66]  ^ s[61];
    t[61]  = s[61]  ^ s[23]  ^ s[0];
    ks = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
    // Padding injects a single 1 on its first step; cb is zero in both phases.
    m  = (fsm == DEC) ? (c[cnt[6:0]] ^ ks) : (cnt == 9'd0);
    ca = (fsm == DEC) || !cnt[7];
    f  = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]);
    s_next = {f ^ m, t[292:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm    <= IDLE;
      s      <= '0;
      c      <= '0;
      p      <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.start) begin
            s      <= bus.state_in;
            c      <= bus.cipher_in;
            cnt    <= '0;
            busy_r <= 1'b1;
            fsm    <= DEC;
          end
        end
        DEC: begin
          s             <= s_next;
          p[cnt[6:0]]   <= m;
          if (cnt == 9'd127) begin
            cnt <= '0;
            fsm <= PAD;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        PAD: begin
          s <= s_next;
          if (cnt == 9'd255) begin
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            fsm    <= IDLE;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.plain_out = p;
  assign bus.state_out = s;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_decryption.sv
// tb/tb_decryption.sv - self-checking bench for the ACORN-128 decryption core
module tb_decryption;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decryption_if ifc ();
  decryption dut (.clk(clk), .rst(rst), .bus(ifc));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [292:0] act, input logic [292:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model: whole-block loops over the cipher equations
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  function automatic logic [292:0] pre(input logic [292:0] s);
    logic [292:0] t;
    t = s;
    t[289] ^= s[235] ^ s[230];
    t[230] ^= s[196] ^ s[193];
    t[193] ^= s[160] ^ s[154];
    t[154] ^= s[111] ^ s[107];
    t[107] ^= s[66] ^ s[61];
    t[61]  ^= s[23] ^ s[0];
    return t;
  endfunction

  function automatic logic keystream(input logic [292:0] s);
    logic [292:0] t;
    t = pre(s);
    return t[12] ^ t[154] ^ maj3(t[235], t[61], t[193]) ^ (t[230] ? t[111] : t[66]);
  endfunction

  function automatic logic [292:0] advance(input logic [292:0] s, input logic m,
                                           input logic ca, input logic cb);
    logic [292:0] t;
    logic fb;
    t  = pre(s);
    fb = t[0] ^ ~t[107] ^ maj3(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & keystream(s));
    return {fb ^ m, t[292:1]};
  endfunction

  function automatic logic [292:0] pad(input logic [292:0] s);
    logic [292:0] r;
    r = s;
    for (int j = 0; j < 256; j++) r = advance(r, j == 0, j < 128, 1'b0);
    return r;
  endfunction

  function automatic logic [420:0] dec(input logic [292:0] st, input logic [127:0] ct);
    logic [292:0] s;
    logic [127:0] pt;
    s = st;
    for (int i = 0; i < 128; i++) begin
      pt[i] = ct[i] ^ keystream(s);
      s = advance(s, pt[i], 1'b1, 1'b0);
    end
    return {pad(s), pt};
  endfunction

  task automatic enc(input logic [292:0] st, input logic [127:0] pt,
                     output logic [127:0] ct, output logic [292:0] fs);
    logic [292:0] s;
    s = st;
    for (int i = 0; i < 128; i++) begin
      ct[i] = pt[i] ^ keystream(s);
      s = advance(s, pt[i], 1'b1, 1'b0);
    end
    fs = pad(s);
  endtask

  // ---------------- cycle model of the handshake plus expected outputs
  wire [420:0] mdec = dec(ifc.state_in, ifc.cipher_in);
  logic         m_busy, m_done;
  int           m_left;
  logic [127:0] exp_p;
  logic [292:0] exp_s;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      exp_p  <= '0;
      exp_s  <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy && ifc.start) begin
        m_busy <= 1'b1;
        m_left <= 384;
        exp_p  <= mdec[127:0];
        exp_s  <= mdec[420:128];
      end else if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", ifc.busy, m_busy);
      chk("done", ifc.done, m_done);
      if (!m_busy) begin
        chk("plain_out", ifc.plain_out, exp_p);
        chk("state_out", ifc.state_out, exp_s);
      end
    end
  end

  // ---------------- stimulus
  task automatic start_block(input logic [292:0] st, input logic [127:0] ct);
    @(negedge clk);
    ifc.start     = 1'b1;
    ifc.state_in  = st;
    ifc.cipher_in = ct;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!ifc.done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", ifc.done, 1'b1);
  endtask

  task automatic gen(output logic [292:0] st, output logic [127:0] pt,
                     output logic [127:0] ct, output logic [292:0] fs);
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[k*32 +: 32] = $urandom;
    st = r[292:0];
    pt = {$urandom, $urandom, $urandom, $urandom};
    enc(st, pt, ct, fs);
  endtask

  task automatic round_trip(input string tag);
    logic [292:0] st, fs;
    logic [127:0] pt, ct;
    int n;
    gen(st, pt, ct, fs);
    start_block(st, ct);
    wait_done(n);
    chk({tag, "_latency"}, n, 384);
    chk({tag, "_plain"}, ifc.plain_out, pt);
    chk({tag, "_state"}, ifc.state_out, fs);
  endtask

  logic [292:0] zs;
  logic [420:0] zr;

  initial begin
    logic [292:0] sa, sb, fa, fb;
    logic [127:0] pa, pb, ca, cb;
    int n;

    ifc.start     = 1'b0;
    ifc.state_in  = '0;
    ifc.cipher_in = '0;

    // Pin the model against hand-derived values.
    zs = '0;
    chk("pin_ks_zero", keystream(zs), 1'b0);
    zs[12] = 1'b1;
    chk("pin_ks_s12", keystream(zs), 1'b1);
    zs = '0;
    chk("pin_adv_zero", advance(zs, 1'b0, 1'b1, 1'b0), {1'b1, 292'h0});
    zr = dec(zs, 128'h0);
    chk("pin_dec_zero", zr[1:0], 2'b00);
    zr = dec(zs, 128'h1);
    chk("pin_dec_one", zr[0], 1'b1);

    repeat (3) @(negedge clk);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_done", ifc.done, 1'b0);
    chk("rst_plain", ifc.plain_out, 128'h0);
    chk("rst_state", ifc.state_out, 293'h0);
    rst = 1'b0;

    // Zero-state known answers
    start_block('0, 128'h0);
    wait_done(n);
    chk("kat0_plain10", ifc.plain_out[1:0], 2'b00);
    start_block('0, 128'h1);
    wait_done(n);
    chk("kat1_plain0", ifc.plain_out[0], 1'b1);

    for (int v = 0; v < 12; v++) round_trip("rt");

    // Latency with an ignored start mid-block
    gen(sa, pa, ca, fa);
    gen(sb, pb, cb, fb);
    start_block(sa, ca);
    repeat (89) @(negedge clk);
    ifc.start     = 1'b1;
    ifc.state_in  = sb;
    ifc.cipher_in = cb;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done(n);
    chk("lat_total", n + 90, 384);
    chk("lat_plain", ifc.plain_out, pa);
    chk("lat_state", ifc.state_out, fa);
    @(negedge clk);
    chk("lat_done_low", ifc.done, 1'b0);
    chk("lat_busy_low", ifc.busy, 1'b0);

    // Back-to-back: B starts in A's done cycle
    gen(sa, pa, ca, fa);
    gen(sb, pb, cb, fb);
    start_block(sa, ca);
    wait_done(n);
    chk("b2b_a_plain", ifc.plain_out, pa);
    ifc.start     = 1'b1;
    ifc.state_in  = sb;
    ifc.cipher_in = cb;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done(n);
    chk("b2b_b_latency", n, 384);
    chk("b2b_b_plain", ifc.plain_out, pb);
    chk("b2b_b_state", ifc.state_out, fb);

    // Reset during padding step 200
    gen(sa, pa, ca, fa);
    start_block(sa, ca);
    repeat (328) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", ifc.busy, 1'b0);
    chk("mid_rst_done", ifc.done, 1'b0);
    chk("mid_rst_plain", ifc.plain_out, 128'h0);
    chk("mid_rst_state", ifc.state_out, 293'h0);
    @(negedge clk);
    rst = 1'b0;
    round_trip("post_rst");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
